swap_burst: RTL and testbench

Parametrised burst swap/copy engine between two internal memory banks A and B. On a start request it exchanges (or copies) a run of `len` consecutive words, one word pair per cycle, between bank A starting at `addra` and bank B starting at `addrb`. It reports progress with a busy/done handshake. A host write port loads the banks and a registered read port observes them. It succeeds the single-word swap block and sits beside it in the vmem test designs.

---
 rtl/swap_burst.sv | 170 +++++++++++++++++
 tb/tb_swap_burst.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/swap_burst.sv
// swap_burst
// Burst swap/copy engine between two internal memory banks A and B.
// A start request in IDLE latches mode/addresses/length. The engine then
// moves one word pair per cycle: swap A<->B, copy A->B or copy B->A.
// Bank addresses wrap modulo DEPTH. A one-cycle done pulse marks the end.
// Host writes are only accepted in IDLE. The read port is registered and
// runs every cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, mode           operation request and kind (3 = illegal -> err)
//   addra, addrb, len     bank A/B start addresses and word count (0..DEPTH)
//   busy, done, err       status: busy in RUN/DONE, done/err one-cycle pulses
//   wr_en, wr_bank,
//   wr_addr, wr_data      host write port (bank 0 = A, 1 = B)
//   rd_bank, rd_addr,
//   rd_data               registered host read port, 1-cycle latency
module swap_burst #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] addra,
    input  logic [AW-1:0] addrb,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic [1:0]    mode_reg, mode_next;
    logic [AW-1:0] addra_reg, addra_next;
    logic [AW-1:0] addrb_reg, addrb_next;
    logic [AW:0]   len_reg, len_next;
    logic          last_word;

    // Per-bank port signals, index 0 = bank A, 1 = bank B.
    logic [1:0]         we;
    logic [1:0][AW-1:0] waddr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0][AW-1:0] xfer_addr;
    logic [1:0][DW-1:0] xfer_rdata;
    logic [1:0][DW-1:0] host_rdata;

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign err  = (state_reg == DONE) && (mode_reg == 2'd3);

    // Word index cnt is never beyond len-1 <= DEPTH-1, so AW bits suffice.
    assign last_word = ({1'b0, cnt_reg} == (len_reg - (AW+1)'(1)));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        addra_next = addra_reg;
        addrb_next = addrb_reg;
        len_next   = len_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mode_next  = mode;
                    addra_next = addra;
                    addrb_next = addrb;
                    len_next   = len;
                    cnt_next   = '0;
                    // Empty or illegal requests skip straight to the done pulse.
                    if ((len == '0) || (mode == 2'd3)) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (last_word) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + AW'(1);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mode_reg  <= '0;
            addra_reg <= '0;
            addrb_reg <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            addra_reg <= addra_next;
            addrb_reg <= addrb_next;
            len_reg   <= len_next;
        end
    end

    // Write-port steering. In RUN each bank takes the other bank's current
    // word, so a swap reads both old values before either write lands.
    // Writes are suppressed while rst is high so an aborted burst stops at
    // exactly the words already moved. In RUN the mode is never 3.
    always_comb begin
        xfer_addr[0] = addra_reg + cnt_reg;
        xfer_addr[1] = addrb_reg + cnt_reg;
        we           = '0;
        waddr[0]     = wr_addr;
        waddr[1]     = wr_addr;
        wdata[0]     = wr_data;
        wdata[1]     = wr_data;
        if (state_reg == RUN) begin
            we[0]    = !rst && (mode_reg != 2'd1);
            we[1]    = !rst && (mode_reg != 2'd2);
            waddr[0] = xfer_addr[0];
            waddr[1] = xfer_addr[1];
            wdata[0] = xfer_rdata[1];
            wdata[1] = xfer_rdata[0];
        end else if (state_reg == IDLE) begin
            we[0] = !rst && wr_en && !wr_bank;
            we[1] = !rst && wr_en && wr_bank;
        end
    end

    // Each bank has one write port, an asynchronous transfer read port and
    // a host read port feeding the registered rd_data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [DW-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[waddr[gi]] <= wdata[gi];
                end
            end

            assign xfer_rdata[gi] = mem[xfer_addr[gi]];
            assign host_rdata[gi] = mem[rd_addr];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= host_rdata[rd_bank];
        end
    end
endmodule

// File: tb/tb_swap_burst.sv
module tb_swap_burst;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic [3:0] addra = '0;
    logic [3:0] addrb = '0;
    logic [4:0] len = '0;
    logic       busy, done, err;
    logic       wr_en = 1'b0;
    logic       wr_bank = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_bank = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: expected read data and expected err flag per done.
    logic [7:0] rd_q[$];
    string      rd_name_q[$];
    logic       done_q[$];
    logic       rd_req = 1'b0;
    logic       rd_chk = 1'b0;

    swap_burst #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .addra(addra), .addrb(addrb), .len(len),
        .busy(busy), .done(done), .err(err),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // A read request sampled at an edge has its data on rd_data after it.
    always @(posedge clk) rd_chk <= rd_req;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents read data or done.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        string      nm;
        logic       ee;
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                e  = rd_q.pop_front();
                nm = rd_name_q.pop_front();
                $display("read %s data 0x%02h expected 0x%02h", nm, rd_data, e);
                chk(nm, int'(rd_data), int'(e));
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                ee = done_q.pop_front();
                $display("done err=%0d expected %0d", err, ee);
                chk("done_err", int'(err), int'(ee));
            end
        end
    end

    task automatic hw(input logic b, input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic b, input logic [3:0] a, input logic [7:0] exp);
        rd_bank = b; rd_addr = a; rd_req = 1'b1;
        rd_q.push_back(exp);
        rd_name_q.push_back($sformatf("%s[%0d]", b ? "B" : "A", a));
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    // Issues one operation and measures busy length and the done position.
    // pulse_at: busy-cycle index at which start is re-pulsed (-1 = never).
    // wr_at: 0 = host write A[2]=0xAA with start, n = during busy cycle n.
    task automatic run_op(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                          input logic [4:0] l, input int pulse_at, input int wr_at);
        int nb;
        int done_at;
        int exp_busy;
        exp_busy = ((l == 0) || (m == 2'd3)) ? 1 : int'(l) + 1;
        mode = m; addra = a; addrb = b; len = l; start = 1'b1;
        wr_en = (wr_at == 0); wr_bank = 1'b0; wr_addr = 4'd2; wr_data = 8'hAA;
        done_q.push_back(m == 2'd3);
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        nb = 0; done_at = -1;
        @(negedge clk);
        while (busy && nb < 100) begin
            nb++;
            if (done) done_at = nb;
            start = (nb == pulse_at);
            wr_en = (nb == wr_at);
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;
        $display("op mode=%0d addra=%0d addrb=%0d len=%0d busy_cycles=%0d done_at=%0d",
                 m, a, b, l, nb, done_at);
        chk("busy_cycles", nb, exp_busy);
        chk("done_cycle", done_at, exp_busy);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        rst = 1'b0;

        // Single swap.
        hw(1'b0, 4'd3, 8'h11);
        hw(1'b1, 4'd7, 8'h22);
        run_op(2'd0, 4'd3, 4'd7, 5'd1, -1, -1);
        rd(1'b0, 4'd3, 8'h22);
        rd(1'b1, 4'd7, 8'h11);

        // Wrapping burst copy A->B.
        for (int i = 0; i < 16; i++) hw(1'b0, 4'(i), 8'(8'h40 + i));
        run_op(2'd1, 4'd14, 4'd0, 5'd4, -1, -1);
        rd(1'b1, 4'd0, 8'h4E);
        rd(1'b1, 4'd1, 8'h4F);
        rd(1'b1, 4'd2, 8'h40);
        rd(1'b1, 4'd3, 8'h41);
        for (int i = 0; i < 16; i++) rd(1'b0, 4'(i), 8'(8'h40 + i));

        // Full-bank swap with reads of A[5] while it runs; word 5 moves at E6.
        for (int i = 0; i < 16; i++) begin
            hw(1'b0, 4'(i), 8'(i));
            hw(1'b1, 4'(i), 8'(8'hF0 | i));
        end
        fork
            run_op(2'd0, 4'd0, 4'd0, 5'd16, -1, -1);
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 8; i++) rd(1'b0, 4'd5, (i < 6) ? 8'h05 : 8'hF5);
            end
        join
        for (int i = 0; i < 16; i++) begin
            rd(1'b0, 4'(i), 8'(8'hF0 | i));
            rd(1'b1, 4'(i), 8'(i));
        end

        // Degenerate operations.
        run_op(2'd0, 4'd0, 4'd0, 5'd0, -1, -1);
        rd(1'b0, 4'd0, 8'hF0);
        rd(1'b1, 4'd0, 8'h00);
        run_op(2'd3, 4'd0, 4'd0, 5'd4, -1, -1);
        for (int i = 0; i < 4; i++) begin
            rd(1'b0, 4'(i), 8'(8'hF0 | i));
            rd(1'b1, 4'(i), 8'(i));
        end
        run_op(2'd1, 4'd4, 4'd4, 5'd4, 2, -1);
        for (int i = 4; i < 8; i++) rd(1'b1, 4'(i), 8'(8'hF0 | i));

        // Host write gating: dropped during RUN, applied with start in IDLE.
        run_op(2'd1, 4'd0, 4'd8, 5'd4, -1, 2);
        rd(1'b0, 4'd2, 8'hF2);
        rd(1'b1, 4'd10, 8'hF2);
        run_op(2'd1, 4'd2, 4'd9, 5'd1, -1, 0);
        rd(1'b1, 4'd9, 8'hAA);
        rd(1'b0, 4'd2, 8'hAA);

        // Reset mid-burst: copy B[8..15] -> A[0..7], reset where word 3 lands.
        for (int i = 0; i < 8; i++) begin
            hw(1'b0, 4'(i), 8'(8'h10 + i));
            hw(1'b1, 4'(8 + i), 8'(8'h80 + i));
        end
        mode = 2'd2; addra = 4'd0; addrb = 4'd8; len = 5'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        $display("op mode=2 addra=0 addrb=8 len=8 aborted by reset");
        for (int i = 0; i < 8; i++) rd(1'b0, 4'(i), (i < 3) ? 8'(8'h80 + i) : 8'(8'h10 + i));
        run_op(2'd2, 4'd0, 4'd8, 5'd8, -1, -1);
        for (int i = 0; i < 8; i++) rd(1'b0, 4'(i), 8'(8'h80 + i));

        repeat (4) @(posedge clk);
        #1;
        chk("queues_empty", rd_q.size() + done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
